// File: rtl/mioc_resp_capture.sv
// MIOC response collector: settles after each applied pattern, samples q/qbar,
// and queues {pattern,q,qbar} records in a first-word-fall-through FIFO.
module mioc_resp_capture #(
  parameter int SETTLE = 4,
  parameter int DEPTH  = 8,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pat_strobe,
  input  logic [3:0]    pat_in,
  input  logic          q,
  input  logic          qbar,
  output logic          rec_valid,
  output logic [5:0]    rec_data,
  input  logic          rec_ready,
  output logic          busy,
  output logic          overflow,
  output logic [CW-1:0] illegal_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(SETTLE + 1);
  localparam logic [CNTW-1:0] RELOAD = CNTW'(SETTLE - 1);
  localparam logic [AW:0]     FULL   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  state_t          state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [3:0]      pat, pat_n;
  logic            smp;

  logic            wr_pend;
  logic [5:0]      wr_rec;

  logic [5:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      pat   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pat   <= pat_n;
    end
  end

  // A strobe in any state (re)starts the settle window with the new pattern.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    smp     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pat_strobe) begin
          state_n = S_SETTLE;
          pat_n   = pat_in;
          cnt_n   = RELOAD;
        end
      end
      S_SETTLE: begin
        if (pat_strobe) begin
          pat_n = pat_in;
          cnt_n = RELOAD;
        end else if (cnt == '0) begin
          state_n = S_SAMPLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_SAMPLE: begin
        smp = 1'b1;
        if (pat_strobe) begin
          state_n = S_SETTLE;
          pat_n   = pat_in;
          cnt_n   = RELOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_SETTLE);

  // Sample is staged one cycle before entering the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend     <= 1'b0;
      wr_rec      <= '0;
      illegal_cnt <= '0;
    end else begin
      wr_pend <= smp;
      if (smp) begin
        wr_rec <= {pat, q, qbar};
      end
      if (smp && (q == qbar) && (illegal_cnt != {CW{1'b1}})) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

  assign full      = (count == FULL);
  assign rec_valid = (count != '0);
  assign pop       = rec_valid & rec_ready;
  assign do_push   = wr_pend & (~full | pop);
  assign rec_data  = rec_valid ? mem[rd_ptr] : 6'd0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (wr_pend && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
